// File: rtl/pipeline_ctrl.sv
// Hazard and pipeline control for the 5-stage RV32I core: stage-valid tracking, load-use and
// data-memory wait stalls, branch flush, EX operand forwarding, memory-wait timeout and perf counters.
module pipeline_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  ResultSrcE_zero,
  input  logic                  PCSrcE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  PCSrcQ,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic [3:0]            valid,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      cnt_retired,
  output logic [CNT_W-1:0]      cnt_stall,
  output logic [CNT_W-1:0]      cnt_flush
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [3:0]        valid_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;
  logic              mem_stall;
  logic              lw_stall;
  logic              pcsrc_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // MEM result beats WB result when both hold the register being read
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (valid_q[2] && RegWriteM && (RdM != '0) && (RdM == rs))
      return 2'b10;
    else if (valid_q[3] && RegWriteW && (RdW != '0) && (RdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    mem_stall = valid_q[2] & MemReqM & ~MemReadyM;
    lw_stall  = valid_q[1] & valid_q[0] & ResultSrcE_zero & (RdE != '0) &
                ((RdE == Rs1D) | (RdE == Rs2D));
    pcsrc_q   = PCSrcE & valid_q[1];

    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mem_stall) begin
      // Whole pipe freezes; a pending redirect waits until memory answers
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall;
      StallD = lw_stall;
      FlushD = pcsrc_q;
      FlushE = pcsrc_q | lw_stall;
    end

    PCSrcQ      = pcsrc_q;
    ForwardAE   = fwd_sel(Rs1E);
    ForwardBE   = fwd_sel(Rs2E);
    valid       = valid_q;
    mem_timeout = ~reset & (timeout_q | (mem_stall & (wait_cnt == WAIT_LAST)));
  end

  // Next-edge state: stage valids, wait counter, sticky timeout, perf counters
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      wait_cnt    <= '0;
      timeout_q   <= 1'b0;
      cnt_retired <= '0;
      cnt_stall   <= '0;
      cnt_flush   <= '0;
    end else begin
      if (mem_stall) begin
        valid_q[3] <= 1'b0;
      end else begin
        valid_q[0] <= FlushD ? 1'b0 : (StallD ? valid_q[0] : 1'b1);
        valid_q[1] <= FlushE ? 1'b0 : valid_q[0];
        valid_q[2] <= valid_q[1];
        valid_q[3] <= valid_q[2];
      end

      if (!mem_stall)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + WAIT_W'(1);

      timeout_q <= mem_timeout;

      if (valid_q[3])
        cnt_retired <= sat_inc(cnt_retired);
      if (StallF)
        cnt_stall <= sat_inc(cnt_stall);
      if (pcsrc_q && !mem_stall)
        cnt_flush <= sat_inc(cnt_flush);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model of stage occupancy, stalls, forwarding and counters.
module tb_pipeline_ctrl;
  localparam int RW   = 5;
  localparam int CW   = 4;
  localparam int TO   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [RW-1:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic ResultSrcE_zero = 0, PCSrcE = 0, RegWriteM = 0, RegWriteW = 0, MemReqM = 0, MemReadyM = 1;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, PCSrcQ, mem_timeout;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] valid;
  logic [CW-1:0] cnt_retired, cnt_stall, cnt_flush;

  always #5 clk = ~clk;

  pipeline_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE_zero(ResultSrcE_zero), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .PCSrcQ(PCSrcQ),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .valid(valid), .mem_timeout(mem_timeout),
    .cnt_retired(cnt_retired), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
  );

  wire [16:0] a_ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, PCSrcQ,
                       ForwardAE, ForwardBE, valid, mem_timeout};
  wire [3*CW-1:0] a_cnt = {cnt_retired, cnt_stall, cnt_flush};

  int checks = 0;
  int errors = 0;

  // Reference model state: which stages hold a live instruction, wait length, counters
  bit [3:0] mv;
  int mw, mret, mstl, mfl;
  bit mto;
  bit e_ms, e_lw, e_q, e_stf, e_fd, e_fe, e_to;
  logic [16:0] e_ctl;
  logic [3*CW-1:0] e_cnt;

  function automatic logic [1:0] fwd_exp(input logic [RW-1:0] rs);
    if (mv[2] && RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (mv[3] && RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(input int x);
    return (x < CMAX) ? x + 1 : x;
  endfunction

  task automatic model_eval();
    e_ms  = mv[2] && MemReqM && !MemReadyM;
    e_lw  = mv[1] && mv[0] && ResultSrcE_zero && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    e_q   = PCSrcE && mv[1];
    e_stf = e_ms || e_lw;
    e_fd  = !e_ms && e_q;
    e_fe  = !e_ms && (e_q || e_lw);
    e_to  = mto || (e_ms && mw + 1 >= TO);
    e_ctl = {e_stf, e_stf, e_ms, e_ms, e_fd, e_fe, e_ms, e_q,
             fwd_exp(Rs1E), fwd_exp(Rs2E), mv, e_to};
    e_cnt = {CW'(mret), CW'(mstl), CW'(mfl)};
  endtask

  task automatic model_tick();
    bit [3:0] nv;
    if (reset) begin
      mv = '0; mw = 0; mto = 0; mret = 0; mstl = 0; mfl = 0;
    end else begin
      if (mv[3]) mret = sat(mret);
      if (e_stf) mstl = sat(mstl);
      if (e_q && !e_ms) mfl = sat(mfl);
      if (e_ms) begin
        mv[3] = 1'b0;
        mw = (mw < TO) ? mw + 1 : mw;
      end else begin
        nv[3] = mv[2];
        nv[2] = mv[1];
        nv[1] = e_fe ? 1'b0 : mv[0];
        nv[0] = e_fd ? 1'b0 : (e_stf ? mv[0] : 1'b1);
        mv = nv;
        mw = 0;
      end
      mto = e_to;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_eval();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle_in();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {ResultSrcE_zero, PCSrcE, RegWriteM, RegWriteW, MemReqM} = '0;
    MemReadyM = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    idle_in();
    for (int i = 0; i < n; i++) begin
      settle();
      checks++;
      if (a_ctl !== e_ctl) begin
        errors++;
        $display("FAIL idle_ctl act=%b exp=%b", a_ctl, e_ctl);
      end
      advance();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_in();
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (a_ctl[16:10] !== 7'b0000111) begin
        errors++;
        $display("FAIL reset_stall_flush act=%b exp=%b", a_ctl[16:10], 7'b0000111);
      end
      advance();
    end
    reset = 1'b0;
    settle();
    checks++;
    if ({valid, mem_timeout, a_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state act=%b/%b/%h exp=0", valid, mem_timeout, a_cnt);
    end
    advance();
  endtask

  task automatic test_load_use();
    idle_cycles(1);
    ResultSrcE_zero = 1'b1; RdE = 5; Rs1D = 5;
    settle();
    checks++;
    if ({StallF, StallD, FlushE, valid} !== {3'b111, 4'b0011} || a_ctl !== e_ctl) begin
      errors++;
      $display("FAIL load_use act=%b exp=%b", a_ctl, e_ctl);
    end
    advance();
    idle_in();
    RdM = 5; RegWriteM = 1'b1; Rs1E = 5;
    settle();
    checks++;
    if (a_ctl !== e_ctl || StallF !== 1'b0) begin
      errors++;
      $display("FAIL load_use_next act=%b exp=%b", a_ctl, e_ctl);
    end
    advance();
  endtask

  task automatic test_branch();
    idle_cycles(4);
    PCSrcE = 1'b1;
    settle();
    checks++;
    if ({PCSrcQ, FlushD, FlushE} !== 3'b111 || a_ctl !== e_ctl) begin
      errors++;
      $display("FAIL branch_taken act=%b exp=%b", a_ctl, e_ctl);
    end
    advance();
    settle();
    checks++;
    if (valid[1:0] !== 2'b00 || {PCSrcQ, FlushD} !== 2'b00 || a_cnt !== e_cnt) begin
      errors++;
      $display("FAIL branch_invalid_e act=%b cnt=%h exp=%b cnt=%h", a_ctl, a_cnt, e_ctl, e_cnt);
    end
    advance();
  endtask

  task automatic test_mem_stall();
    idle_cycles(4);
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if ({StallF, StallD, StallE, StallM, FlushW} !== 5'b11111 || a_ctl !== e_ctl) begin
        errors++;
        $display("FAIL mem_stall_%0d act=%b exp=%b", i, a_ctl, e_ctl);
      end
      advance();
    end
    MemReadyM = 1'b1;
    settle();
    checks++;
    if ({StallF, FlushW, valid[3], mem_timeout} !== 4'b0000 || a_ctl !== e_ctl) begin
      errors++;
      $display("FAIL mem_release act=%b exp=%b", a_ctl, e_ctl);
    end
    advance();
    MemReqM = 1'b0;
  endtask

  task automatic test_timeout();
    idle_cycles(3);
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++;
      if (mem_timeout !== (i >= TO - 1) || a_ctl !== e_ctl) begin
        errors++;
        $display("FAIL timeout_cycle_%0d act=%b exp=%b", i, a_ctl, e_ctl);
      end
      advance();
    end
    MemReadyM = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (mem_timeout !== 1'b1 || StallF !== 1'b0) begin
        errors++;
        $display("FAIL timeout_sticky act=%b%b exp=10", mem_timeout, StallF);
      end
      advance();
    end
    MemReqM = 1'b0;
  endtask

  task automatic test_forward();
    idle_cycles(4);
    RdM = 7; RdW = 7; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs1E = 7; Rs2E = 7;
    settle();
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b1010) begin
      errors++;
      $display("FAIL fwd_mem_prio act=%b exp=1010", {ForwardAE, ForwardBE});
    end
    RegWriteM = 1'b0;
    #1;
    checks++;
    if (ForwardAE !== 2'b01) begin
      errors++;
      $display("FAIL fwd_wb act=%b exp=01", ForwardAE);
    end
    RdM = 0; RdW = 0; Rs1E = 0; RegWriteM = 1'b1;
    #1;
    checks++;
    if (ForwardAE !== 2'b00) begin
      errors++;
      $display("FAIL fwd_x0 act=%b exp=00", ForwardAE);
    end
    advance();
  endtask

  task automatic test_saturation();
    idle_cycles(20);
    settle();
    checks++;
    if (cnt_retired !== CW'(CMAX) || a_cnt !== e_cnt) begin
      errors++;
      $display("FAIL cnt_saturate act=%h exp=%h", a_cnt, e_cnt);
    end
    advance();
  endtask

  task automatic test_branch_during_stall();
    idle_cycles(4);
    MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if ({FlushD, FlushE} !== 2'b00 || a_ctl !== e_ctl) begin
        errors++;
        $display("FAIL branch_in_stall act=%b exp=%b", a_ctl, e_ctl);
      end
      advance();
    end
    MemReadyM = 1'b1;
    settle();
    checks++;
    if ({FlushD, FlushE} !== 2'b11 || a_ctl !== e_ctl) begin
      errors++;
      $display("FAIL branch_after_stall act=%b exp=%b", a_ctl, e_ctl);
    end
    advance();
    idle_in();
  endtask

  task automatic test_reset_mid_stall();
    idle_cycles(4);
    MemReqM = 1'b1; MemReadyM = 1'b0;
    settle();
    advance();
    reset = 1'b1;
    settle();
    checks++;
    if (a_ctl[16:10] !== 7'b0000111) begin
      errors++;
      $display("FAIL reset_in_stall act=%b exp=0000111", a_ctl[16:10]);
    end
    advance();
    reset = 1'b0;
    settle();
    checks++;
    if ({StallF, valid, a_cnt} !== '0 || a_ctl !== e_ctl) begin
      errors++;
      $display("FAIL after_reset_stall act=%b cnt=%h exp=%b", a_ctl, a_cnt, e_ctl);
    end
    advance();
    idle_in();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      Rs1D = RW'($urandom_range(0, 7)); Rs2D = RW'($urandom_range(0, 7));
      Rs1E = RW'($urandom_range(0, 7)); Rs2E = RW'($urandom_range(0, 7));
      RdE  = RW'($urandom_range(0, 7)); RdM  = RW'($urandom_range(0, 7));
      RdW  = RW'($urandom_range(0, 7));
      ResultSrcE_zero = 1'($urandom_range(0, 1));
      PCSrcE    = ($urandom_range(0, 5) == 0);
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemReqM   = 1'($urandom_range(0, 1));
      MemReadyM = ($urandom_range(0, 3) != 0);
      settle();
      checks++;
      if (reset ? (a_ctl[16:10] !== 7'b0000111) : (a_ctl !== e_ctl)) begin
        errors++;
        $display("FAIL rand_ctl_%0d act=%b exp=%b", i, a_ctl, e_ctl);
      end
      checks++;
      if (a_cnt !== e_cnt) begin
        errors++;
        $display("FAIL rand_cnt_%0d act=%h exp=%h", i, a_cnt, e_cnt);
      end
      advance();
    end
    reset = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_stall();
    test_timeout();
    test_forward();
    test_saturation();
    test_branch_during_stall();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
